qif_neuron_scheduler: RTL and testbench



---
 rtl/qif_neuron_scheduler.sv | 141 ++++++++++++++
 tb/tb_qif_neuron_scheduler.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/qif_neuron_scheduler.sv
// qif_neuron_scheduler: time-multiplexed QIF update of N_NEURONS neurons with a valid/ready spike stream.
// Optional per-neuron refractory counters are enabled with `define QIF_REFRACTORY_EN.
module qif_neuron_scheduler #(
  parameter int N_NEURONS = 4,
  parameter int IDX_W = 2,
  parameter logic signed [7:0] VPEAK = 8'sd50,
  parameter logic signed [7:0] VRESET = -8'sd20,
  parameter int REFRACT = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cur_valid,
  output logic             cur_ready,
  input  logic [IDX_W-1:0] cur_idx,
  input  logic [7:0]       cur_data,
  input  logic             step_start,
  output logic             busy,
  output logic             step_done,
  output logic             spike_valid,
  input  logic             spike_ready,
  output logic [IDX_W-1:0] spike_idx,
  input  logic [IDX_W-1:0] mon_idx,
  output logic [7:0]       mon_v
);
  if (IDX_W != $clog2(N_NEURONS) || N_NEURONS < 2 || N_NEURONS > 16 || REFRACT < 0 || REFRACT > 255) begin : g_bad_cfg
    $error("qif_neuron_scheduler: invalid parameter set");
  end
  typedef enum logic [1:0] {IDLE, UPDATE, EMIT, DONE} state_t;
  state_t state_q, state_d;
  logic [IDX_W-1:0] ptr_q, ptr_d, spike_idx_q, spike_idx_d;
  logic signed [7:0] v_q [N_NEURONS];
  logic signed [7:0] v_d [N_NEURONS];
  logic signed [7:0] b_q [N_NEURONS];
  logic signed [7:0] b_d [N_NEURONS];
  logic busy_q, busy_d, step_done_q, step_done_d, spike_valid_q, spike_valid_d, cur_ready_q, cur_ready_d;
  logic signed [7:0] v_cur, b_cur, qif;
  logic signed [15:0] v_ext;
  logic [15:0] sq;
  logic signed [11:0] sum;
  logic last, hold, fire;
`ifdef QIF_REFRACTORY_EN
  logic [7:0] rc_q [N_NEURONS];
  logic [7:0] rc_d [N_NEURONS];
  assign hold = rc_q[ptr_q] != 8'd0;
`else
  assign hold = 1'b0;
`endif
  assign v_cur = v_q[ptr_q];
  assign b_cur = b_q[ptr_q];
  assign v_ext = 16'(v_cur);
  assign sq = v_ext * v_ext;
  // 12 bits hold the worst case 127 + 31 + 1024 without wrapping
  assign sum = 12'(v_cur) + 12'(b_cur >>> 2) + 12'(sq >> 4);
  assign qif = (sum > 12'sd127) ? 8'sd127 : (sum < -12'sd128) ? -8'sd128 : sum[7:0];
  assign last = ptr_q == IDX_W'(N_NEURONS - 1);
  assign fire = !hold && (v_cur >= VPEAK);
  assign cur_ready = cur_ready_q;
  assign busy = busy_q;
  assign step_done = step_done_q;
  assign spike_valid = spike_valid_q;
  assign spike_idx = spike_idx_q;
  assign mon_v = v_q[mon_idx];
  always_comb begin
    state_d = state_q;
    ptr_d = ptr_q;
    v_d = v_q;
    b_d = b_q;
    spike_valid_d = spike_valid_q;
    spike_idx_d = spike_idx_q;
`ifdef QIF_REFRACTORY_EN
    rc_d = rc_q;
`endif
    case (state_q)
      IDLE: begin
        if (cur_valid) b_d[cur_idx] = cur_data;
        if (step_start) begin
          state_d = UPDATE;
          ptr_d = '0;
        end
      end
      UPDATE: begin
`ifdef QIF_REFRACTORY_EN
        if (hold) rc_d[ptr_q] = rc_q[ptr_q] - 8'd1;
        if (fire) rc_d[ptr_q] = 8'(REFRACT);
`endif
        if (fire) begin
          v_d[ptr_q] = VRESET;
          spike_valid_d = 1'b1;
          spike_idx_d = ptr_q;
          state_d = EMIT;
        end else begin
          if (!hold) v_d[ptr_q] = qif;
          if (last) state_d = DONE;
          else ptr_d = ptr_q + 1'b1;
        end
      end
      EMIT: begin
        if (spike_ready) begin
          spike_valid_d = 1'b0;
          state_d = last ? DONE : UPDATE;
          ptr_d = last ? ptr_q : ptr_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = state_d != IDLE;
    cur_ready_d = state_d == IDLE;
    step_done_d = state_d == DONE;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      ptr_q <= '0;
      spike_idx_q <= '0;
      busy_q <= 1'b0;
      step_done_q <= 1'b0;
      spike_valid_q <= 1'b0;
      cur_ready_q <= 1'b1;
      for (int i = 0; i < N_NEURONS; i++) begin
        v_q[i] <= VRESET;
        b_q[i] <= '0;
`ifdef QIF_REFRACTORY_EN
        rc_q[i] <= '0;
`endif
      end
    end else begin
      state_q <= state_d;
      ptr_q <= ptr_d;
      spike_idx_q <= spike_idx_d;
      busy_q <= busy_d;
      step_done_q <= step_done_d;
      spike_valid_q <= spike_valid_d;
      cur_ready_q <= cur_ready_d;
      v_q <= v_d;
      b_q <= b_d;
`ifdef QIF_REFRACTORY_EN
      rc_q <= rc_d;
`endif
    end
  end
endmodule

// File: tb/tb_qif_neuron_scheduler.sv
// tb_qif_neuron_scheduler: directed scoreboard bench for qif_neuron_scheduler.
module tb_qif_neuron_scheduler;
  localparam int N = 4;
  localparam int IW = 2;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic cur_valid = 1'b0;
  logic cur_ready;
  logic [IW-1:0] cur_idx = '0;
  logic [7:0] cur_data = '0;
  logic step_start = 1'b0;
  logic busy, step_done, spike_valid;
  logic spike_ready = 1'b1;
  logic [IW-1:0] spike_idx;
  logic [IW-1:0] mon_idx = '0;
  logic [7:0] mon_v;
  int tests = 0;
  int fails = 0;
  int sb[$];

  always #5 clk = ~clk;

  qif_neuron_scheduler #(.N_NEURONS(N), .IDX_W(IW)) dut (
    .clk(clk), .rst(rst), .cur_valid(cur_valid), .cur_ready(cur_ready),
    .cur_idx(cur_idx), .cur_data(cur_data), .step_start(step_start),
    .busy(busy), .step_done(step_done), .spike_valid(spike_valid),
    .spike_ready(spike_ready), .spike_idx(spike_idx), .mon_idx(mon_idx), .mon_v(mon_v)
  );

  task automatic check(input string nm, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic peek(input string nm, input int idx, input int exp);
    mon_idx = IW'(idx);
    #1;
    check(nm, int'($signed(mon_v)), exp);
  endtask

  task automatic write_cur(input int idx, input int data);
    @(posedge clk); #1;
    cur_valid = 1'b1; cur_idx = IW'(idx); cur_data = 8'(data);
    @(posedge clk); #1;
    cur_valid = 1'b0;
  endtask

  task automatic do_reset();
    @(posedge clk); #1; rst = 1'b1;
    @(posedge clk); #1; rst = 1'b0;
  endtask

  task automatic wait_done(output int lat);
    lat = 0;
    do begin
      @(negedge clk); lat++;
    end while (!step_done && lat < 60);
  endtask

  task automatic run_pass(input int exp_lat, input int stall, input int hold_v);
    int lat, held;
    lat = 0; held = 0;
    @(posedge clk); #1;
    step_start = 1'b1; spike_ready = (stall == 0);
    @(posedge clk); #1;
    step_start = 1'b0; mon_idx = 1;
    do begin
      @(negedge clk); lat++;
      if (lat == 1) check("busy_rise", busy, 1);
      if (spike_valid && !spike_ready) begin
        held++;
        check("bp_idx", spike_idx, sb.size() > 0 ? sb[0] : -1);
        check("bp_hold_v1", int'($signed(mon_v)), hold_v);
        if (held == stall) begin
          @(posedge clk); #1; spike_ready = 1'b1;
        end
      end
    end while (!step_done && lat < 60);
    check("pass_lat", lat, exp_lat);
    @(posedge clk); #1;
    spike_ready = 1'b1;
    check("busy_fall", busy, 0);
  endtask

  // Monitor: every accepted spike must match the oldest expected index.
  always @(negedge clk) begin
    if (!rst && spike_valid && spike_ready) begin
      if (sb.size() == 0) check("spike_unexpected", spike_idx, -1);
      else check("spike_idx", spike_idx, sb.pop_front());
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_done", step_done, 0);
    check("rst_valid", spike_valid, 0);
    check("rst_spike_idx", spike_idx, 0);
    check("rst_cur_ready", cur_ready, 1);
    for (int i = 0; i < N; i++) peek("rst_v", i, -20);

    // Integration: B[0]=40, four passes
    write_cur(0, 40);
    run_pass(5, 0, 0); peek("p1_v0", 0, 15); peek("p1_v1", 1, 5);
    run_pass(5, 0, 0); peek("p2_v0", 0, 39); peek("p2_v1", 1, 6);
    run_pass(5, 0, 0); peek("p3_v0_sat", 0, 127); peek("p3_v1", 1, 8);
    sb.push_back(0);
    run_pass(6, 0, 0); peek("p4_v0_reset", 0, -20); peek("p4_v1", 1, 12);
    run_pass(5, 0, 0);
`ifdef QIF_REFRACTORY_EN
    peek("p5_v0_refract", 0, -20);
`else
    peek("p5_v0_resume", 0, 15);
`endif
    peek("p5_v1", 1, 21);

    // Backpressure: five stalled EMIT cycles
    do_reset();
    write_cur(0, 40);
    repeat (3) run_pass(5, 0, 0);
    peek("bp_pre_v0", 0, 127); peek("bp_pre_v1", 1, 8);
    sb.push_back(0);
    run_pass(11, 5, 8);
    peek("bp_v0", 0, -20); peek("bp_v1", 1, 12);

    // Busy rules: write and restart during a pass are ignored
    @(posedge clk); #1 step_start = 1'b1;
    @(posedge clk); #1 cur_valid = 1'b1; cur_idx = 2; cur_data = 8'd100;
    @(negedge clk);
    check("busy_cur_ready", cur_ready, 0);
    check("busy_busy", busy, 1);
    @(posedge clk); #1 cur_valid = 1'b0; step_start = 1'b0;
    wait_done(lat);
    check("busy_lat", lat, 4);
    repeat (3) begin
      @(negedge clk);
      check("no_restart", busy, 0);
    end
    peek("busy_v2_b_unchanged", 2, 21); peek("busy_v1", 1, 21);

    // Reset mid-pass while a spike is pending
    run_pass(5, 0, 0);
    run_pass(5, 0, 0);
    peek("pre_rst_v1", 1, 127);
    @(posedge clk); #1 step_start = 1'b1; spike_ready = 1'b0;
    @(posedge clk); #1 step_start = 1'b0;
    lat = 0;
    do begin
      @(negedge clk); lat++;
    end while (!spike_valid && lat < 20);
    check("pre_rst_valid", spike_valid, 1);
    #2 rst = 1'b1;
    #1;
    check("mid_rst_valid", spike_valid, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_cur_ready", cur_ready, 1);
    check("mid_rst_spike_idx", spike_idx, 0);
    @(posedge clk); #1 rst = 1'b0; spike_ready = 1'b1;
    for (int i = 0; i < N; i++) peek("mid_rst_v", i, -20);
    @(negedge clk);
    check("post_rst_busy", busy, 0);

    // Same-cycle write and start: pass uses the new B
    @(posedge clk); #1;
    cur_valid = 1'b1; cur_idx = 1; cur_data = 8'h80; step_start = 1'b1;
    @(posedge clk); #1 cur_valid = 1'b0; step_start = 1'b0;
    wait_done(lat);
    check("same_lat", lat, 5);
    peek("same_v1", 1, -27); peek("same_v0", 0, 5);
    run_pass(5, 0, 0);
    peek("same_v1_p2", 1, -14);

    check("sb_empty", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
